// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the core's load/store request/response protocol. Accepts one
// request at a time, waits LATENCY edges, performs a little-endian byte-addressed
// access on internal storage and presents the result under a valid/ready handshake.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [64:0] DEPTH_EXT = 65'(DEPTH_BYTES);
    localparam logic [AW:0] DEPTH_IDX = (AW+1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          cap_write;
    logic [1:0]    cap_size;
    logic          cap_unsigned;
    logic [63:0]   cap_addr;
    logic [63:0]   cap_wdata;

    logic [7:0]    mem [DEPTH_BYTES];

    logic          acc_write;
    logic [1:0]    acc_size;
    logic          acc_unsigned;
    logic [63:0]   acc_addr;
    logic [63:0]   acc_wdata;

    logic [64:0]   acc_nbytes;
    logic [64:0]   acc_end;
    logic          acc_misaligned;
    logic          acc_oor;
    logic          acc_err;

    logic [63:0]   raw_rdata;
    logic [63:0]   next_rdata;
    logic          accept;
    logic          enter_resp;

    // Sign- or zero-extend the low 2^size bytes of a raw little-endian read.
    function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic signed [63:0] ext;
        logic               sx;
        case (size)
            2'd0: begin
                sx  = ~uns & raw[7];
                ext = {{56{sx}}, raw[7:0]};
            end
            2'd1: begin
                sx  = ~uns & raw[15];
                ext = {{48{sx}}, raw[15:0]};
            end
            2'd2: begin
                sx  = ~uns & raw[31];
                ext = {{32{sx}}, raw[31:0]};
            end
            default: begin
                sx  = 1'b0;
                ext = raw;
            end
        endcase
        return ext;
    endfunction

    // With LATENCY=1 the access happens on the acceptance edge, so the live
    // request fields are used in IDLE; otherwise the captured copy is used.
    always_comb begin
        if (state == IDLE) begin
            acc_write    = req_write;
            acc_size     = req_size;
            acc_unsigned = req_unsigned;
            acc_addr     = req_addr;
            acc_wdata    = req_wdata;
        end else begin
            acc_write    = cap_write;
            acc_size     = cap_size;
            acc_unsigned = cap_unsigned;
            acc_addr     = cap_addr;
            acc_wdata    = cap_wdata;
        end
    end

    // Alignment and range check at 65 bits so address wrap-around is caught.
    always_comb begin
        acc_nbytes     = 65'd1 << acc_size;
        acc_end        = {1'b0, acc_addr} + acc_nbytes;
        acc_misaligned = (({1'b0, acc_addr} & (acc_nbytes - 65'd1)) != 65'd0);
        acc_oor        = (acc_end > DEPTH_EXT);
        acc_err        = acc_misaligned | acc_oor;
    end

    // Gather up to eight bytes from the access address; bytes past the end read as 0.
    always_comb begin
        raw_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            if (({1'b0, acc_addr[AW-1:0]} + (AW+1)'(k)) < DEPTH_IDX) begin
                raw_rdata[8*k +: 8] = mem[acc_addr[AW-1:0] + AW'(k)];
            end
        end
    end

    // Response data and the edge on which the access is performed.
    always_comb begin
        if (acc_err || acc_write) begin
            next_rdata = '0;
        end else begin
            next_rdata = extend_load(raw_rdata, acc_size, acc_unsigned);
        end
        accept     = (state == IDLE) && req_valid;
        enter_resp = (accept && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == CW'(1)));
    end

    // Capture the request fields at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write    <= req_write;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= next_rdata;
                            resp_err   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (enter_resp) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= next_rdata;
                        resp_err   <= acc_err;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: cleared on reset, written little-endian on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (enter_resp && acc_write && !acc_err) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < acc_nbytes[3:0]) begin
                    mem[acc_addr[AW-1:0] + AW'(k)] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: a LATENCY=2 instance carries most
// scenarios, a LATENCY=1 instance covers the single-edge-latency variant.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, resp_ready, resp_err;

    logic        l1_req_valid, l1_req_ready, l1_req_write, l1_req_unsigned;
    logic [1:0]  l1_req_size;
    logic [63:0] l1_req_addr, l1_req_wdata, l1_resp_rdata;
    logic        l1_resp_valid, l1_resp_ready, l1_resp_err;

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
        .req_size(l1_req_size), .req_unsigned(l1_req_unsigned), .req_addr(l1_req_addr),
        .req_wdata(l1_req_wdata), .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
        .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; called at a falling edge in IDLE.
    // n = cycles from the request cycle to the first cycle with resp_valid high.
    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] r, output logic e, output int n);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_unsigned = ~u;
        req_addr = a ^ 64'h8; req_wdata = ~d;
        n = 1;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        r = resp_rdata;
        e = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // Same transaction shape on the LATENCY=1 instance.
    task automatic xact1(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] r, output logic e, output int n);
        l1_req_valid = 1'b1; l1_req_write = w; l1_req_size = sz; l1_req_unsigned = u;
        l1_req_addr = a; l1_req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        l1_req_valid = 1'b0; l1_req_wdata = ~d; l1_req_addr = a ^ 64'h8;
        n = 1;
        while (l1_resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        r = l1_resp_rdata;
        e = l1_resp_err;
        l1_resp_ready = 1'b1;
        @(negedge clk);
        l1_resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_size = 2'd0; l1_req_unsigned = 1'b0;
        l1_req_addr = '0; l1_req_wdata = '0; l1_resp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        xact(1'b0, 2'd3, 1'b0, 64'h0, 64'h0, rd, er, lat);
        chk("ld0_data", rd, 64'h0);
        chk("ld0_err", 64'(er), 64'd0);
        chk("ld0_lat", 64'(lat), 64'd2);

        // Double store, byte loads
        xact(1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211, rd, er, lat);
        chk("sd10_rdata", rd, 64'h0);
        chk("sd10_err", 64'(er), 64'd0);
        chk("sd10_lat", 64'(lat), 64'd2);
        xact(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, rd, er, lat);
        chk("lb10", rd, 64'h11);
        xact(1'b0, 2'd0, 1'b0, 64'h17, 64'h0, rd, er, lat);
        chk("lb17", rd, 64'hFFFFFFFFFFFFFF88);
        xact(1'b0, 2'd0, 1'b1, 64'h17, 64'h0, rd, er, lat);
        chk("lbu17", rd, 64'h88);
        xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, er, lat);
        chk("ld10", rd, 64'h8877665544332211);

        // Partial store; upper wdata bits must be ignored
        xact(1'b1, 2'd1, 1'b0, 64'h12, 64'h123456789ABCBEEF, rd, er, lat);
        chk("sh12_err", 64'(er), 64'd0);
        xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, er, lat);
        chk("ld10_after_sh", rd, 64'h88776655BEEF2211);
        xact(1'b0, 2'd2, 1'b0, 64'h14, 64'h0, rd, er, lat);
        chk("lw14", rd, 64'hFFFFFFFF88776655);
        xact(1'b0, 2'd1, 1'b1, 64'h12, 64'h0, rd, er, lat);
        chk("lhu12", rd, 64'hBEEF);

        // Timing with back-pressure on the response
        chk("hold_ready_pre", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h10; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 64'h0;
        chk("hold_valid_c1", 64'(resp_valid), 64'd0);
        chk("hold_ready_c1", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("hold_valid_c2", 64'(resp_valid), 64'd1);
        chk("hold_rdata_c2", resp_rdata, 64'h88776655BEEF2211);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, 64'h88776655BEEF2211);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_hs_req_ready", 64'(req_ready), 64'd1);
        chk("post_hs_valid", 64'(resp_valid), 64'd0);
        chk("post_hs_rdata", resp_rdata, 64'h0);

        // Errors
        xact(1'b0, 2'd2, 1'b0, 64'h12, 64'h0, rd, er, lat);
        chk("lw12_err", 64'(er), 64'd1);
        chk("lw12_rdata", rd, 64'h0);
        chk("lw12_lat", 64'(lat), 64'd2);
        xact(1'b1, 2'd2, 1'b0, 64'h11, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
        chk("sw11_err", 64'(er), 64'd1);
        xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, er, lat);
        chk("ld10_after_sw_err", rd, 64'h88776655BEEF2211);
        xact(1'b1, 2'd3, 1'b0, 64'hFC, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
        chk("sdFC_err", 64'(er), 64'd1);
        chk("sdFC_lat", 64'(lat), 64'd2);
        xact(1'b0, 2'd3, 1'b0, 64'hF8, 64'h0, rd, er, lat);
        chk("ldF8_unchanged", rd, 64'h0);
        chk("ldF8_err", 64'(er), 64'd0);
        xact(1'b0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, rd, er, lat);
        chk("ld_wrap_err", 64'(er), 64'd1);
        chk("ld_wrap_rdata", rd, 64'h0);
        chk("ld_wrap_lat", 64'(lat), 64'd2);
        xact(1'b1, 2'd0, 1'b0, 64'h100, 64'h5A, rd, er, lat);
        chk("sb100_err", 64'(er), 64'd1);

        // Last in-range double, then byte-wrap store must not alias onto it
        xact(1'b1, 2'd3, 1'b0, 64'hF8, 64'hA1B2C3D4E5F60718, rd, er, lat);
        chk("sdF8_err", 64'(er), 64'd0);
        xact(1'b1, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h5A, rd, er, lat);
        chk("sb_wrap_err", 64'(er), 64'd1);
        xact(1'b0, 2'd3, 1'b0, 64'hF8, 64'h0, rd, er, lat);
        chk("ldF8", rd, 64'hA1B2C3D4E5F60718);
        xact(1'b0, 2'd0, 1'b0, 64'hFF, 64'h0, rd, er, lat);
        chk("lbFF", rd, 64'hFFFFFFFFFFFFFFA1);
        chk("lbFF_err", 64'(er), 64'd0);

        // Reset during WAIT drops the request
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h20; req_wdata = 64'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst_in_wait", 64'(req_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_no_resp", 64'(resp_valid), 64'd0);
        xact(1'b0, 2'd3, 1'b0, 64'h20, 64'h0, rd, er, lat);
        chk("ld20_after_rst", rd, 64'h0);
        xact(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, er, lat);
        chk("ld10_cleared", rd, 64'h0);

        // LATENCY=1 variant
        chk("l1_req_ready", 64'(l1_req_ready), 64'd1);
        xact1(1'b1, 2'd3, 1'b0, 64'h20, 64'h1234, rd, er, lat);
        chk("l1_sd_lat", 64'(lat), 64'd1);
        chk("l1_sd_err", 64'(er), 64'd0);
        chk("l1_post_hs_ready", 64'(l1_req_ready), 64'd1);
        xact1(1'b0, 2'd3, 1'b0, 64'h20, 64'h0, rd, er, lat);
        chk("l1_ld_lat", 64'(lat), 64'd1);
        chk("l1_ld_data", rd, 64'h1234);
        xact1(1'b0, 2'd1, 1'b0, 64'h21, 64'h0, rd, er, lat);
        chk("l1_lh_mis_err", 64'(er), 64'd1);
        chk("l1_lh_mis_lat", 64'(lat), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder. It sits on the memory side of the processor's load/store path and is the responder end of the request/response protocol that a multi-cycle or pipelined core uses to issue `ld/lw/lh/lb/sd/sw/sh/sb`. It accepts one request at a time, waits a fixed latency, performs the access on byte-addressed little-endian storage, and returns a response under a valid/ready handshake.

## Interface
- `DEPTH_BYTES`, 256: storage size in bytes; must be a multiple of 8.
- `LATENCY`, 2: edges from request acceptance to response; must be 1 or more.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `req_unsigned` in 1: loads zero-extend when 1 and sign-extend when 0; ignored for stores.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data; the low 8·2^size bits are used.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: requester accepts the response.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: access was misaligned or out of range.

## Operation
- States are IDLE, WAIT and RESP.
- **Acceptance.** A request is accepted on an edge where IDLE and `req_valid` are both 1.
  - All `req_*` fields are captured at that edge. Later changes to the inputs are ignored.
- **Latency counting.** After acceptance:
  - If LATENCY is 1, the next state is RESP.
  - Otherwise the next state is WAIT with the counter set to LATENCY−1.
  - WAIT decrements the counter every edge and moves to RESP on the edge where the counter reaches 0.
- **Access.** The access executes on the edge that enters RESP.
  - Stores write 2^size bytes starting at `addr`, little-endian, LSB at the lowest address. No other byte changes.
  - Loads read the same bytes, extend them to 64 bits, and register the result into `resp_rdata`.
- **Errors.** An error occurs when `addr mod 2^size != 0` or `addr + 2^size > DEPTH_BYTES`. Address arithmetic is done at 65 bits, so wrap-around counts as out of range.
  - On error, `resp_err` is 1, `resp_rdata` is 0 and storage is unchanged.
  - The latency is the same as for a successful access.
- **Response.** RESP holds `resp_valid`=1 and keeps `resp_rdata`/`resp_err` stable until an edge with `resp_ready`=1, then returns to IDLE.
- **Reset.** On `reset`=1:
  - The state goes to IDLE and any in-flight request is dropped; no write is performed for it.
  - Every storage byte is cleared to 0.
  - Reset takes priority over every other event.

## Timing
- Reset values: `req_ready`=1 (IDLE), `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- `req_ready` is a function of state only. It is 0 in WAIT and RESP; there is no combinational path from `req_valid`.
- Request accepted at edge E0 → `resp_valid` first high in the cycle after edge E0+LATENCY−1. With LATENCY=2 it is high two cycles after the request cycle.
- Response handshake at edge Er → IDLE after Er, so `req_ready`=1 in the next cycle.
  - There is no same-edge turnaround. A new request is accepted at Er+1 at the earliest.
  - Throughput is one request per LATENCY+1 cycles when `resp_ready` is held at 1.
- `resp_rdata`/`resp_err` are registered and valid only while `resp_valid`=1. Outside RESP they return to 0.
- A store is visible to a load accepted any time after its response handshake.
- Reset asserted in WAIT or RESP: outputs are at their reset values in the next cycle.

## Test plan
- **Reset state.** Assert `reset` for 2 cycles → `req_ready`=1, `resp_valid`=0. A `ld` from 0x00 returns 0 with `resp_err`=0.
- **Double store and byte loads.**
  - `sd` 0x8877665544332211 to 0x10, then `lb` 0x10 → `resp_rdata`=0x11.
  - `lb` 0x17 (signed) → 0xFFFFFFFFFFFFFF88; `lbu` 0x17 → 0x88.
  - `ld` 0x10 → full value back.
- **Partial store.** `sh` 0xBEEF to 0x12 over the pattern above → `ld` 0x10 = 0x88776655BEEF2211. `lw` 0x14 signed → 0xFFFFFFFF88776655.
- **Timing.**
  - LATENCY=2: `resp_valid` rises exactly 2 cycles after the request cycle.
  - Holding `resp_ready`=0 for 5 cycles keeps `resp_valid`/`resp_rdata` stable.
  - `req_ready` stays low throughout and rises the cycle after the handshake.
- **Errors.** Each of the following → `resp_err`=1, `resp_rdata`=0, same latency, storage unchanged (verify by readback):
  - `lw` at 0x12 (misaligned).
  - `sd` at DEPTH_BYTES−4 (out of range).
  - `ld` at 0xFFFFFFFFFFFFFFF8 (wrap-around).
- **Reset mid-operation.** Accept `sd` 0x1234 to 0x20, then assert `reset` during WAIT → no response is produced. Post-reset `ld` 0x20 returns 0. LATENCY=1 variant: response in the cycle immediately after acceptance.
